cpu_fetch_unit: RTL
===================

CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: ack wait limit, used only when FETCH_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  16  byte address of the requested instruction.
REQ-007 imem_rdata  input  16  instruction word, valid when imem_ack=1.
REQ-008 imem_ack  input  1  read-complete strobe from memory.
REQ-009 ldPC2  input  1  from controller: next PC = PC+2.
REQ-010 ldPCz  input  1  from controller: next PC = branch target.
REQ-011 ldOff11to16, ldOff8to16, ldOff5to16  input  1 each  offset-width select from controller.
REQ-012 instr  output  16  instruction register (IR).
REQ-013 opcode  output  5  IR[15:11], to the controller.
REQ-014 off16  output  16  sign-extended offset.
REQ-015 pc  output  16  current PC.
REQ-016 instr_valid  output  1  IR holds a valid instruction; controller outputs are consumed this cycle.
REQ-017 fetch_err  output  1  sticky fetch-timeout flag; tied 0 when FETCH_TIMEOUT_EN is undefined.

Function
REQ-018 FSM states are FETCH, EXEC and HALT.
REQ-019 FETCH: imem_req=1 and imem_addr=pc, held stable until the edge on which imem_ack=1.
  - That edge loads IR from imem_rdata and enters EXEC.
  - Minimum fetch latency is 1 cycle (ack in the first FETCH cycle).
REQ-020 EXEC: imem_req=0 and instr_valid=1 for exactly one cycle; the next-PC update occurs on the exiting edge.
REQ-021 Next PC in EXEC:
  - ldPCz=1: pc+2+(off16<<1), modulo 2^16, go to FETCH.
  - Else ldPC2=1: pc+2, modulo 2^16, go to FETCH.
  - Neither: pc unchanged, go to HALT.
  - ldPCz has priority when both are asserted.
REQ-022 HALT: imem_req=0, instr_valid=0, IR and pc held; left only by reset.
REQ-023 off16 is combinational from IR:
  - ldOff11to16: sext(IR[10:0]); else ldOff8to16: sext(IR[7:0]); else ldOff5to16: sext(IR[4:0]); else 16'h0000.
  - Priority 11 > 8 > 5 when more than one select is asserted.
REQ-024 imem_ack is ignored when imem_req=0.
REQ-025 PC wrap: pc=16'hFFFE with ldPC2 gives 16'h0000.

Reset
REQ-026 rst_n low immediately sets state=FETCH, pc=RESET_PC, IR=0, imem_req=0, instr_valid=0, fetch_err=0, timeout counter=0.
REQ-027 Reset mid-fetch or mid-EXEC abandons the transaction; imem_req is first asserted in the cycle after rst_n deasserts.

Configuration
REQ-028 Macro FETCH_TIMEOUT_EN defined:
  - A counter increments each FETCH cycle without ack and clears on ack.
  - When it reaches TIMEOUT_CYCLES without ack, fetch_err goes to 1 and the FSM enters HALT.
REQ-029 FETCH_TIMEOUT_EN undefined: no counter, fetch_err=0, FETCH waits indefinitely.

Structure
REQ-030 Shared package/header cpu_pkg holds:
  - FSM state encodings.
  - Opcode field positions [15:11].
  - Offset field widths (11/8/5).
  - Default RESET_PC.
REQ-031 Sign-extension lives in one sub-module, fetch_offset_sext; the controller-side decode is not duplicated here.

Verification
REQ-032 Reset, then ack on the first FETCH cycle with rdata=16'h8805 -> imem_addr=0000, then opcode=5'b10001, instr_valid pulses for 1 cycle.
REQ-033 Sequential run, ldPC2=1 every EXEC, ack delay 3 cycles -> pc 0000,0002,0004; addr/req stable during the wait.
REQ-034 pc=0010, IR=16'h8FFE, ldOff11to16=1, ldPCz=1 -> off16=16'hFFFE, next pc=0010+2-4=000E.
REQ-035 ldPC2=ldPCz=0 in EXEC -> HALT; acks ignored, pc held; rst_n low -> pc=RESET_PC.
REQ-036 With FETCH_TIMEOUT_EN defined and no ack for 16 cycles -> fetch_err=1, imem_req=0, HALT.
REQ-037 rst_n asserted mid-FETCH -> imem_req drops in the same cycle, with no clock edge required.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU fetch unit: FSM encodings, IR field layout,
// offset field widths and the default reset PC.
package cpu_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  localparam int OFF11_W = 11;
  localparam int OFF8_W  = 8;
  localparam int OFF5_W  = 5;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_offset_sext.sv
// Sign-extends the IR offset field selected by the controller to 16 bits.
// Priority among selects is 11-bit > 8-bit > 5-bit; no select yields zero.
module fetch_offset_sext
  import cpu_pkg::*;
(
  input  logic [10:0] ir_low,
  input  logic        sel11,
  input  logic        sel8,
  input  logic        sel5,
  output logic [15:0] off16
);

  // Priority mux over the three sign-extended offset widths.
  always_comb begin
    off16 = 16'h0000;
    if (sel11) begin
      off16 = {{(16 - OFF11_W){ir_low[OFF11_W-1]}}, ir_low[OFF11_W-1:0]};
    end else if (sel8) begin
      off16 = {{(16 - OFF8_W){ir_low[OFF8_W-1]}}, ir_low[OFF8_W-1:0]};
    end else if (sel5) begin
      off16 = {{(16 - OFF5_W){ir_low[OFF5_W-1]}}, ir_low[OFF5_W-1:0]};
    end else begin
      off16 = 16'h0000;
    end
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: FETCH/EXEC/HALT sequencing, PC and IR registers.
// Optional fetch-ack timeout enabled by defining FETCH_TIMEOUT_EN.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        ldPC2,
  input  logic        ldPCz,
  input  logic        ldOff11to16,
  input  logic        ldOff8to16,
  input  logic        ldOff5to16,
  output logic [15:0] instr,
  output logic [4:0]  opcode,
  output logic [15:0] off16,
  output logic [15:0] pc,
  output logic        instr_valid,
  output logic        fetch_err
);

  logic [1:0]  state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic [15:0] ir_r, ir_s;
  logic        req_r, req_s;
  logic        valid_r, valid_s;
  logic [15:0] off16_s;
  logic [15:0] seq_pc_s;
  logic [15:0] branch_pc_s;
  logic        timeout_hit_s;

  fetch_offset_sext u_sext (
    .ir_low (ir_r[10:0]),
    .sel11  (ldOff11to16),
    .sel8   (ldOff8to16),
    .sel5   (ldOff5to16),
    .off16  (off16_s)
  );

  assign seq_pc_s    = pc_r + 16'd2;
  assign branch_pc_s = seq_pc_s + {off16_s[14:0], 1'b0};

`ifdef FETCH_TIMEOUT_EN
  logic [15:0] cnt_r;
  logic        err_r;

  assign timeout_hit_s = (state_r == ST_FETCH) && req_r && !imem_ack &&
                         (cnt_r == 16'(TIMEOUT_CYCLES - 1));

  // Counts unacknowledged request cycles; cleared outside an active fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'h0000;
    end else if ((state_r == ST_FETCH) && req_r && !imem_ack) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= 16'h0000;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign fetch_err = err_r;
`else
  logic [15:0] unused_timeout_s;

  assign unused_timeout_s = 16'(TIMEOUT_CYCLES);
  assign timeout_hit_s    = 1'b0;
  assign fetch_err        = 1'b0;
`endif

  // Next-state logic. req_r starts low out of reset so the first request
  // appears one cycle after rst_n deasserts; acks are ignored until then.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    req_s   = req_r;
    valid_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (!req_r) begin
          req_s = 1'b1;
        end else if (imem_ack) begin
          ir_s    = imem_rdata;
          state_s = ST_EXEC;
          req_s   = 1'b0;
          valid_s = 1'b1;
        end else if (timeout_hit_s) begin
          state_s = ST_HALT;
          req_s   = 1'b0;
        end else begin
          req_s = 1'b1;
        end
      end
      ST_EXEC: begin
        if (ldPCz) begin
          pc_s    = branch_pc_s;
          state_s = ST_FETCH;
          req_s   = 1'b1;
        end else if (ldPC2) begin
          pc_s    = seq_pc_s;
          state_s = ST_FETCH;
          req_s   = 1'b1;
        end else begin
          state_s = ST_HALT;
          req_s   = 1'b0;
        end
      end
      ST_HALT: begin
        req_s = 1'b0;
      end
      default: begin
        state_s = ST_HALT;
        req_s   = 1'b0;
      end
    endcase
  end

  // State, PC, IR and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      ir_r    <= 16'h0000;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
      req_r   <= req_s;
      valid_r <= valid_s;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = ir_r;
  assign opcode      = ir_r[OPC_MSB:OPC_LSB];
  assign off16       = off16_s;
  assign instr_valid = valid_r;

endmodule
